sobel_stream: RTL

SOBEL_STREAM -- requirements
Module: sobel_stream

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_window.sv | 38 +++
 rtl/sobel_stream.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the streaming Sobel edge detector: FSM states,
// 3x3 kernel coefficients and the output saturation helper.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } sobel_state_e;

    // Coefficients indexed p1..p9 in raster order (0 = top-left)
    localparam int KX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int KY [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    function automatic int sat_max(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

endpackage

// File: rtl/sobel_window.sv
// Line-buffer shift register spanning two lines plus three pixels; exposes
// the 3x3 neighbourhood whose center lies IMG_WIDTH+1 shifts behind the newest.
module sobel_window #(
    parameter int IMG_WIDTH = 720,
    parameter int PIXEL_W   = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               shift_en,
    input  logic [PIXEL_W-1:0] din,
    output logic [PIXEL_W-1:0] taps [9]
);

    localparam int DEPTH = 2 * IMG_WIDTH + 3;

    logic [PIXEL_W-1:0] sr [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (shift_en) begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    // sr[0] is the newest pixel, i.e. the bottom-right neighbour of the center
    assign taps[0] = sr[2*IMG_WIDTH+2];
    assign taps[1] = sr[2*IMG_WIDTH+1];
    assign taps[2] = sr[2*IMG_WIDTH];
    assign taps[3] = sr[IMG_WIDTH+2];
    assign taps[4] = sr[IMG_WIDTH+1];
    assign taps[5] = sr[IMG_WIDTH];
    assign taps[6] = sr[2];
    assign taps[7] = sr[1];
    assign taps[8] = sr[0];

endmodule

// File: rtl/sobel_stream.sv
// FIFO-to-FIFO streaming Sobel filter: one output per input pixel in raster
// order, either saturated gradient magnitude or a thresholded binary map.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int PIXEL_W    = 8,
    parameter int MODE       = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               in_rd_en,
    input  logic               in_empty,
    input  logic [PIXEL_W-1:0] in_dout,
    input  logic [PIXEL_W-1:0] threshold,
    output logic               out_wr_en,
    input  logic               out_full,
    output logic [PIXEL_W-1:0] out_din,
    output logic               frame_done
);

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int PMAX  = (1 << PIXEL_W) - 1;

    localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(IMG_WIDTH + 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(NPIX - 1);

    sobel_state_e             state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic                     shift_en;
    logic [PIXEL_W-1:0]       shift_din;
    logic [PIXEL_W-1:0]       taps [9];
    int                       gx_sum, gy_sum;
    logic signed [PIXEL_W+2:0] gx, gy;
    logic [PIXEL_W+3:0]       mag_sum;
    logic [PIXEL_W+2:0]       mag;
    logic [PIXEL_W-1:0]       mag_sat;
    logic                     over_thr;
    logic                     border;

    function automatic logic [PIXEL_W+2:0] abs_g(input logic signed [PIXEL_W+2:0] v);
        return v[PIXEL_W+2] ? $unsigned(-v) : $unsigned(v);
    endfunction

    sobel_window #(
        .IMG_WIDTH (IMG_WIDTH),
        .PIXEL_W   (PIXEL_W)
    ) u_window (
        .clock    (clock),
        .reset_n  (reset_n),
        .shift_en (shift_en),
        .din      (shift_din),
        .taps     (taps)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // cnt counts reads through FILL and RUN (absolute pixel index), then writes in FLUSH
    always_comb begin
        state_nxt  = state;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        shift_en   = 1'b0;
        shift_din  = in_dout;
        frame_done = 1'b0;
        case (state)
            IDLE: state_nxt = FILL;
            FILL: begin
                in_rd_en = !in_empty;
                shift_en = in_rd_en;
                if (in_rd_en && cnt == EDGE_LAST) state_nxt = RUN;
            end
            RUN: begin
                in_rd_en  = !in_empty && !out_full;
                out_wr_en = in_rd_en;
                shift_en  = in_rd_en;
                if (in_rd_en && cnt == RUN_LAST) state_nxt = FLUSH;
            end
            FLUSH: begin
                out_wr_en = !out_full;
                shift_en  = out_wr_en;
                shift_din = '0;
                if (out_wr_en && cnt == EDGE_LAST) begin
                    state_nxt  = FILL;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (shift_en) begin
            if ((state == RUN && cnt == RUN_LAST) || (state == FLUSH && cnt == EDGE_LAST))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (out_wr_en) begin
            if (col == COL_W'(IMG_WIDTH - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_comb begin
        gx_sum = 0;
        gy_sum = 0;
        for (int i = 0; i < 9; i++) begin
            gx_sum += KX[i] * int'(taps[i]);
            gy_sum += KY[i] * int'(taps[i]);
        end
        gx       = (PIXEL_W+3)'(gx_sum);
        gy       = (PIXEL_W+3)'(gy_sum);
        mag_sum  = (PIXEL_W+4)'(abs_g(gx)) + (PIXEL_W+4)'(abs_g(gy));
        mag      = (PIXEL_W+3)'(mag_sum >> 1);
        mag_sat  = PIXEL_W'(sat_max(int'(mag), PMAX));
        over_thr = int'(mag) >= int'(threshold);
        border   = (row == '0) || (row == ROW_W'(IMG_HEIGHT - 1)) ||
                   (col == '0) || (col == COL_W'(IMG_WIDTH - 1));
        out_din  = '0;
        if (out_wr_en && !border) begin
            if (MODE == 0)     out_din = mag_sat;
            else if (over_thr) out_din = '1;
        end
    end

endmodule
